// File: rtl/ysyx_22050854_mul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_22050854_mul_pkg                                              |
// | Shared state, op encodings and signedness codes for the mul ctrl.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ysyx_22050854_mul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [1:0] FN_MUL    = 2'b00;
  localparam logic [1:0] FN_MULH   = 2'b01;
  localparam logic [1:0] FN_MULHSU = 2'b10;
  localparam logic [1:0] FN_MULHU  = 2'b11;

  localparam logic [1:0] MS_SS = 2'b11;
  localparam logic [1:0] MS_SU = 2'b10;
  localparam logic [1:0] MS_UU = 2'b00;

  // MULW and MUL both need only the low half, so they multiply signed x signed.
  function automatic logic [1:0] fn_signed(input logic [1:0] fn, input logic w);
    if (w) return MS_SS;
    case (fn)
      FN_MULHSU: return MS_SU;
      FN_MULHU:  return MS_UU;
      default:   return MS_SS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050854_mul_rcache.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_22050854_mul_rcache                                           |
// | Single-entry multiply result cache: entry, match compare, write.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ysyx_22050854_mul_rcache #(
  parameter int XLEN     = 64,
  parameter int CACHE_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lk_src1_i,
  input  logic [XLEN-1:0] lk_src2_i,
  input  logic [1:0]      lk_sign_i,
  input  logic            lk_any_i,
  output logic            hit_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_src1_i,
  input  logic [XLEN-1:0] wr_src2_i,
  input  logic [1:0]      wr_sign_i,
  input  logic [XLEN-1:0] wr_hi_i,
  input  logic [XLEN-1:0] wr_lo_i
);

  localparam logic c_en = (CACHE_EN != 0);

  logic            valid_q;
  logic [XLEN-1:0] src1_q, src2_q, hi_q, lo_q;
  logic [1:0]      sign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      sign_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (wr_en_i) begin
      valid_q <= 1'b1;
      src1_q  <= wr_src1_i;
      src2_q  <= wr_src2_i;
      sign_q  <= wr_sign_i;
      hi_q    <= wr_hi_i;
      lo_q    <= wr_lo_i;
    end
  end

  // Low-half lookups ignore signedness; high-half lookups must match it.
  assign hit_o = c_en & valid_q & (lk_src1_i == src1_q) & (lk_src2_i == src2_q)
               & (lk_any_i | (lk_sign_i == sign_q));
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_22050854_mul_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ysyx_22050854_mul_ctrl                                             |
// | EXU <-> Booth multiplier sequencer with flush and result reuse.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ysyx_22050854_mul_ctrl
  import ysyx_22050854_mul_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int TAG_W    = 5,
  parameter int CACHE_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_fn,
  input  logic             op_w,
  input  logic [XLEN-1:0]  op_src1,
  input  logic [XLEN-1:0]  op_src2,
  input  logic [TAG_W-1:0] op_tag,
  input  logic             flush,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [XLEN-1:0]  res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             mul_valid,
  output logic             mul_flush,
  output logic             mul_w,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  mul_a,
  output logic [XLEN-1:0]  mul_b,
  input  logic             mul_ready,
  input  logic             mul_out_valid,
  input  logic [XLEN-1:0]  mul_hi,
  input  logic [XLEN-1:0]  mul_lo
);

  function automatic logic [XLEN-1:0] sel_res(input logic [1:0] fn, input logic w,
                                             input logic [XLEN-1:0] hi, input logic [XLEN-1:0] lo);
    if (w) return {{(XLEN-32){lo[31]}}, lo[31:0]};
    return (fn == FN_MUL) ? lo : hi;
  endfunction

  state_e           state_q, state_d;
  logic [XLEN-1:0]  src1_q, src2_q, res_q;
  logic [1:0]       fn_q;
  logic             w_q;
  logic [TAG_W-1:0] tag_q;

  logic             w_accept, w_hit, w_capture, w_drive;
  logic [XLEN-1:0]  w_c_hi, w_c_lo;

  assign w_accept  = op_valid & (state_q == ST_IDLE) & ~flush;
  assign w_capture = (state_q == ST_BUSY) & mul_out_valid & ~flush;

  ysyx_22050854_mul_rcache #(.XLEN(XLEN), .CACHE_EN(CACHE_EN)) u_rcache (
    .clk       (clk),
    .rst       (rst),
    .lk_src1_i (op_src1),
    .lk_src2_i (op_src2),
    .lk_sign_i (fn_signed(op_fn, op_w)),
    .lk_any_i  (op_w | (op_fn == FN_MUL)),
    .hit_o     (w_hit),
    .hi_o      (w_c_hi),
    .lo_o      (w_c_lo),
    .wr_en_i   (w_capture & ~w_q),
    .wr_src1_i (src1_q),
    .wr_src2_i (src2_q),
    .wr_sign_i (fn_signed(fn_q, w_q)),
    .wr_hi_i   (mul_hi),
    .wr_lo_i   (mul_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (w_accept) state_d = w_hit ? ST_RESP : ST_ISSUE;
      ST_ISSUE: if (flush) state_d = ST_IDLE;
                else if (mul_ready) state_d = ST_BUSY;
      // A flush racing the result lands straight in IDLE; nothing left to drain.
      ST_BUSY:  if (mul_out_valid) state_d = flush ? ST_IDLE : ST_RESP;
                else if (flush) state_d = ST_DRAIN;
      ST_RESP:  if (flush | res_ready) state_d = ST_IDLE;
      ST_DRAIN: if (mul_out_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src1_q <= '0;
      src2_q <= '0;
      fn_q   <= '0;
      w_q    <= 1'b0;
      tag_q  <= '0;
      res_q  <= '0;
    end else begin
      if (w_accept) begin
        src1_q <= op_src1;
        src2_q <= op_src2;
        fn_q   <= op_fn;
        w_q    <= op_w;
        tag_q  <= op_tag;
        if (w_hit) res_q <= sel_res(op_fn, op_w, w_c_hi, w_c_lo);
      end
      if (w_capture) res_q <= sel_res(fn_q, w_q, mul_hi, mul_lo);
    end
  end

  assign w_drive = (state_q == ST_ISSUE) | (state_q == ST_BUSY);

  always_comb begin
    op_ready   = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    res_valid  = (state_q == ST_RESP);
    mul_valid  = (state_q == ST_ISSUE) & ~flush;
    mul_flush  = (state_q == ST_BUSY) & flush & ~mul_out_valid;
    mul_w      = w_drive & w_q;
    mul_signed = w_drive ? fn_signed(fn_q, w_q) : 2'b00;
    mul_a      = w_drive ? src1_q : '0;
    mul_b      = w_drive ? src2_q : '0;
  end

  assign res_data = res_q;
  assign res_tag  = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050854_mul_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ysyx_22050854_mul_ctrl                                          |
// | Scoreboarded bench with a behavioural Booth multiplier stand-in.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ysyx_22050854_mul_ctrl;

  localparam int XLEN  = 64;
  localparam int TAG_W = 5;
  // Edges from multiplier handshake to the edge that raises mul_out_valid.
  localparam int LAT64 = 5;
  localparam int LAT32 = 3;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             rst, op_valid, op_w, flush, res_ready;
  logic [1:0]       op_fn;
  logic [XLEN-1:0]  op_src1, op_src2;
  logic [TAG_W-1:0] op_tag;
  logic             op_ready, busy, res_valid;
  logic [XLEN-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic             mul_valid, mul_flush, mul_w;
  logic [1:0]       mul_signed;
  logic [XLEN-1:0]  mul_a, mul_b;
  logic             mul_ready;
  logic             mul_out_valid = 1'b0;
  logic [XLEN-1:0]  mul_hi = '0, mul_lo = '0;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [63:0] d; logic [4:0] t; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ysyx_22050854_mul_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W), .CACHE_EN(1)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_fn(op_fn),
    .op_w(op_w), .op_src1(op_src1), .op_src2(op_src2), .op_tag(op_tag), .flush(flush),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .mul_valid(mul_valid), .mul_flush(mul_flush), .mul_w(mul_w),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_ready(mul_ready),
    .mul_out_valid(mul_out_valid), .mul_hi(mul_hi), .mul_lo(mul_lo)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Architectural reference, written from the ISA definitions.
  function automatic logic [63:0] ref_res(input logic [1:0] fn, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  p;
    logic [127:0] q;
    if (w) begin
      p = a * b;
      return {{32{p[31]}}, p[31:0]};
    end
    case (fn)
      2'b00:   return a * b;
      2'b01:   q = 128'($signed(a)) * 128'($signed(b));
      2'b10:   q = 128'($signed(a)) * {64'b0, b};
      default: q = {64'b0, a} * {64'b0, b};
    endcase
    return q[127:64];
  endfunction

  function automatic logic [1:0] exp_sign(input logic [1:0] fn, input logic w);
    if (w || fn == 2'b00 || fn == 2'b01) return 2'b11;
    return (fn == 2'b10) ? 2'b10 : 2'b00;
  endfunction

  // Multiplier stand-in: garbage on hi/lo except in the out_valid cycle.
  logic         m_busy = 1'b0;
  int           m_cnt, m_lat;
  logic [127:0] m_prod;
  assign mul_ready = ~m_busy & ~mul_out_valid;

  always @(posedge clk) begin
    mul_out_valid <= 1'b0;
    mul_hi <= {$urandom, $urandom};
    mul_lo <= {$urandom, $urandom};
    if (rst) begin
      m_busy <= 1'b0;
    end else if (mul_valid && mul_ready) begin
      logic [127:0] ea, eb;
      if (mul_w) begin
        ea = {{96{mul_a[31]}}, mul_a[31:0]};
        eb = {{96{mul_b[31]}}, mul_b[31:0]};
      end else begin
        ea = mul_signed[1] ? {{64{mul_a[63]}}, mul_a} : {64'b0, mul_a};
        eb = mul_signed[0] ? {{64{mul_b[63]}}, mul_b} : {64'b0, mul_b};
      end
      m_prod <= ea * eb;
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_lat  <= mul_w ? LAT32 : LAT64;
    end else if (m_busy) begin
      if (m_cnt == m_lat) begin
        m_busy        <= 1'b0;
        mul_out_valid <= 1'b1;
        mul_hi        <= m_prod[127:64];
        mul_lo        <= m_prod[63:0];
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", res_data, e.d);
        chk("res_tag", res_tag, e.t);
      end
    end
  end

  // exp_hit: 1 = must hit, 0 = must miss, -1 = either.
  task automatic do_op(input logic [1:0] fn, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag, input int exp_hit);
    int   lat, wt;
    bit   saw_mv;
    logic [1:0] sg;
    logic sw;
    exp_t e;
    e.d = ref_res(fn, w, a, b);
    e.t = tag;
    sb.push_back(e);
    wt = 0;
    while (!op_ready && wt < 100) begin @(negedge clk); wt++; end
    chk("op_ready_wait", op_ready, 1);
    op_valid = 1'b1; op_fn = fn; op_w = w; op_src1 = a; op_src2 = b; op_tag = tag;
    @(posedge clk); #1 op_valid = 1'b0;
    lat = 0; saw_mv = 0; sg = 2'b00; sw = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (mul_valid) begin saw_mv = 1; sg = mul_signed; sw = mul_w; end
    end while (!res_valid && lat < 100);
    if (exp_hit == 1) begin
      chk("hit_latency", lat, 1);
      chk("hit_no_mul_valid", saw_mv, 0);
    end else if (exp_hit == 0) begin
      chk("miss_latency", lat, (w ? LAT32 : LAT64) + 3);
      chk("miss_mul_signed", sg, exp_sign(fn, w));
      chk("miss_mul_w", sw, w);
    end else begin
      chk("res_within_bound", lat < 100, 1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] pool [4];
    logic [63:0] hold_d;
    logic [4:0]  hold_t;
    bit          moved, seen_res;
    int          wt;

    rst = 1; op_valid = 0; op_w = 0; op_fn = 0; op_src1 = 0; op_src2 = 0; op_tag = 0;
    flush = 0; res_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mul_valid", mul_valid, 0);
    chk("rst_mul_signed_a", {mul_signed, mul_a, mul_w, mul_flush}, 0);
    rst = 0;
    @(posedge clk); #1;

    do_op(2'b01, 1'b0, ONES, 64'd2, 5'd1, 0);        // MULH -1*2
    do_op(2'b00, 1'b0, ONES, 64'd2, 5'd2, 1);        // MUL reuses lo
    do_op(2'b11, 1'b0, ONES, ONES, 5'd3, 0);         // MULHU
    do_op(2'b10, 1'b0, ONES, ONES, 5'd4, 0);         // MULHSU: signedness differs
    do_op(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd5, 0); // MULW, must not overwrite entry
    do_op(2'b10, 1'b0, ONES, ONES, 5'd6, 1);
    do_op(2'b00, 1'b0, ONES, ONES, 5'd7, 1);
    do_op(2'b01, 1'b0, ONES, ONES, 5'd8, 0);
    do_op(2'b00, 1'b1, ONES, ONES, 5'd9, 1);         // MULW hits a full-width entry

    pool[0] = ONES; pool[1] = 64'd2; pool[2] = 64'h7FFF_FFFF; pool[3] = 64'h8000_0000_0000_0003;
    for (int i = 0; i < 10; i++)
      do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)],
            pool[$urandom_range(0, 3)], 5'($urandom_range(0, 31)), -1);

    // Flush two cycles into BUSY.
    op_valid = 1; op_fn = 2'b00; op_w = 0; op_src1 = 64'h1234_5678_9ABC_DEF0;
    op_src2 = 64'h0FED_CBA9; op_tag = 5'd20;
    @(posedge clk); #1 op_valid = 0;
    wt = 0;
    do begin @(negedge clk); wt++; end while (!(mul_valid && mul_ready) && wt < 50);
    chk("flush_issue_seen", mul_valid & mul_ready, 1);
    @(negedge clk);
    @(negedge clk);
    flush = 1; #1;
    chk("flush_mul_flush_pulse", mul_flush, 1);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_mul_flush_single", mul_flush, 0);
    chk("flush_drain_busy", {busy, op_ready}, 2'b10);
    seen_res = 0; wt = 0;
    while (!mul_out_valid && wt < 50) begin
      if (res_valid) seen_res = 1;
      @(negedge clk); wt++;
    end
    chk("drain_out_valid_seen", mul_out_valid, 1);
    chk("drain_op_ready_low", op_ready, 0);
    @(negedge clk);
    chk("drain_op_ready_back", op_ready, 1);
    chk("drain_no_res_valid", seen_res | res_valid, 0);
    @(posedge clk); #1;
    do_op(2'b00, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9, 5'd21, 0);

    // Hold the result in RESP, then reset mid-response.
    res_ready = 0;
    op_valid = 1; op_fn = 2'b01; op_w = 0; op_src1 = 64'hDEAD_BEEF_0000_0001;
    op_src2 = 64'hFFFF_0000_1234_5678; op_tag = 5'd17;
    @(posedge clk); #1 op_valid = 0;
    wt = 0;
    while (!res_valid && wt < 100) begin @(negedge clk); wt++; end
    chk("hold_res_valid", res_valid, 1);
    chk("hold_res_data", res_data, ref_res(2'b01, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_1234_5678));
    hold_d = res_data; hold_t = res_tag;
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_data !== hold_d || res_tag !== hold_t || op_ready !== 1'b0 || res_valid !== 1'b1)
        moved = 1;
    end
    chk("hold_stable", moved, 0);
    chk("hold_tag", hold_t, 5'd17);
    rst = 1;
    @(negedge clk);
    chk("rst2_ready_busy_valid", {op_ready, busy, res_valid}, 3'b100);
    chk("rst2_res", {res_data, res_tag}, 0);
    chk("rst2_mul_outputs", {mul_valid, mul_flush, mul_w, mul_signed, mul_a, mul_b}, 0);
    rst = 0; res_ready = 1;
    @(posedge clk); #1;
    do_op(2'b00, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'hFFFF_0000_1234_5678, 5'd18, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
